// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first once the instruction is held.
// Latency: request combinational in IDLE; hold valid one cycle after the memory response pulse.
// Backpressure: request re-presented unchanged while m_req_ready=0; one transaction outstanding at a time.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            i_resp_valid,
  output logic [XLEN-1:0] i_resp_data,
  input  logic            d_req_valid,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic            d_req_fcn,
  input  logic [2:0]      d_req_typ,
  input  logic [XLEN-1:0] d_req_data,
  output logic            d_resp_valid,
  output logic [XLEN-1:0] d_resp_data,
  input  logic            retire,
  output logic            m_req_valid,
  input  logic            m_req_ready,
  output logic [XLEN-1:0] m_req_addr,
  output logic [XLEN-1:0] m_req_data,
  output logic            m_req_fcn,
  output logic [2:0]      m_req_typ,
  input  logic            m_resp_valid,
  input  logic [XLEN-1:0] m_resp_data
);

  localparam logic [2:0] MT_WU = 3'd7;

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

  state_t          state_q, state_d;
  logic            i_hold_vld_q, i_hold_vld_d;
  logic [XLEN-1:0] i_hold_dat_q, i_hold_dat_d;
  logic            d_hold_vld_q, d_hold_vld_d;
  logic [XLEN-1:0] d_hold_dat_q, d_hold_dat_d;
  // High in the cycle right after reset so no request escapes before the core settles.
  logic            rst_dly_q;

  logic sel_d;
  logic sel_i;
  logic can_issue;

  // Request selection, memory-port drive, next-state and hold updates.
  always_comb begin
    state_d      = state_q;
    i_hold_vld_d = i_hold_vld_q;
    i_hold_dat_d = i_hold_dat_q;
    d_hold_vld_d = d_hold_vld_q;
    d_hold_dat_d = d_hold_dat_q;
    m_req_valid  = 1'b0;
    m_req_addr   = '0;
    m_req_data   = '0;
    m_req_fcn    = 1'b0;
    m_req_typ    = 3'd0;

    can_issue = (state_q == IDLE) && !rst && !rst_dly_q;
    // A data access belongs to the held instruction, so it waits for that hold.
    sel_d = can_issue && d_req_valid && i_hold_vld_q && !d_hold_vld_q;
    sel_i = can_issue && !sel_d && i_req_valid && !i_hold_vld_q;

    if (sel_d) begin
      m_req_valid = 1'b1;
      m_req_addr  = d_req_addr;
      m_req_data  = d_req_data;
      m_req_fcn   = d_req_fcn;
      m_req_typ   = d_req_typ;
    end else if (sel_i) begin
      m_req_valid = 1'b1;
      m_req_addr  = i_req_addr;
      m_req_typ   = MT_WU;
    end

    unique case (state_q)
      IDLE: begin
        if (m_req_valid && m_req_ready) begin
          state_d = sel_d ? D_WAIT : I_WAIT;
        end
      end
      I_WAIT: begin
        if (m_resp_valid) begin
          state_d      = IDLE;
          i_hold_vld_d = 1'b1;
          i_hold_dat_d = m_resp_data;
        end
      end
      D_WAIT: begin
        if (m_resp_valid) begin
          state_d      = IDLE;
          d_hold_vld_d = 1'b1;
          d_hold_dat_d = m_resp_data;
        end
      end
      default: state_d = IDLE;
    endcase

    // Retire only counts once an instruction is held; data words are kept for debug visibility.
    if (retire && i_hold_vld_q) begin
      i_hold_vld_d = 1'b0;
      d_hold_vld_d = 1'b0;
    end
  end

  // State and hold registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      i_hold_vld_q <= 1'b0;
      i_hold_dat_q <= '0;
      d_hold_vld_q <= 1'b0;
      d_hold_dat_q <= '0;
      rst_dly_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      i_hold_vld_q <= i_hold_vld_d;
      i_hold_dat_q <= i_hold_dat_d;
      d_hold_vld_q <= d_hold_vld_d;
      d_hold_dat_q <= d_hold_dat_d;
      rst_dly_q    <= 1'b0;
    end
  end

  assign i_resp_valid = i_hold_vld_q;
  assign i_resp_data  = i_hold_dat_q;
  assign d_resp_valid = d_hold_vld_q;
  assign d_resp_data  = d_hold_dat_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: width of addresses and data on all ports.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_req_valid  in  1  instruction fetch request; the core holds it high.
REQ-005 i_req_addr  in  XLEN  fetch address (PC).
REQ-006 i_resp_valid  out  1  fetched instruction available; held until retire.
REQ-007 i_resp_data  out  XLEN  fetched instruction word.
REQ-008 d_req_valid  in  1  data request (decode mem_en).
REQ-009 d_req_addr  in  XLEN  data address.
REQ-010 d_req_fcn  in  1  0 = read (M_XRD), 1 = write (M_XWR).
REQ-011 d_req_typ  in  3  mask type (MT_*), passed through unchanged.
REQ-012 d_req_data  in  XLEN  store data.
REQ-013 d_resp_valid  out  1  data access complete; held until retire.
REQ-014 d_resp_data  out  XLEN  load data (don't-care for stores).
REQ-015 retire  in  1  core commits the current instruction (not stalled).
REQ-016 m_req_valid / m_req_ready  out / in  1 / 1  shared-memory request handshake.
REQ-017 m_req_addr, m_req_data  out  XLEN each  muxed address and store data.
REQ-018 m_req_fcn, m_req_typ  out  1, 3  muxed function and type; a fetch drives fcn=0, typ=MT_WU.
REQ-019 m_resp_valid, m_resp_data  in  1, XLEN  memory response, 1-cycle pulse, one per accepted request; a write also returns a pulse.

Function
REQ-020 FSM states: IDLE, I_WAIT, D_WAIT; at most one memory transaction outstanding.
REQ-021 Hold registers: i_hold (valid and data), d_hold (valid and data); i_resp_valid = i_hold.valid and d_resp_valid = d_hold.valid (registered outputs).
REQ-022 IDLE, data select: if d_req_valid && i_hold.valid && !d_hold.valid, drive m_req_valid=1 with the d_req_* fields.
REQ-023 IDLE, fetch select: else if i_req_valid && !i_hold.valid, drive m_req_valid=1 with i_req_addr, fcn=0, typ=MT_WU, data=0.
REQ-024 IDLE, no selection: else m_req_valid=0 and all m_req_* fields = 0.
REQ-025 Data has priority over fetch; a data request is never issued while i_hold.valid=0.
REQ-026 IDLE -> I_WAIT or D_WAIT only in a cycle with m_req_valid && m_req_ready; otherwise stay in IDLE and re-present the request (m_req_* stable while not ready).
REQ-027 m_req_valid=0 in I_WAIT and D_WAIT.
REQ-028 I_WAIT: on m_resp_valid, i_hold <= {1, m_resp_data}, go to IDLE.
REQ-029 D_WAIT: on m_resp_valid, d_hold <= {1, m_resp_data}, go to IDLE.
REQ-030 Latency: request accepted in cycle N, response in cycle N+k (k>=1), hold valid visible in cycle N+k+1.
REQ-031 retire with i_hold.valid=1, in any state: clears i_hold.valid and d_hold.valid next cycle; the data registers keep their value.
REQ-032 retire with i_hold.valid=0: ignored.
REQ-033 retire in the same cycle as an IDLE data select: the request is still issued, and d_hold is cleared by retire.
REQ-034 The core raises retire only after all required holds are valid; the arbiter does not check this.
REQ-035 m_resp_valid in IDLE (spurious): ignored, no state change.
REQ-036 Back-to-back: after retire, the next fetch may issue in the first IDLE cycle with i_hold.valid=0.

Reset
REQ-037 rst=1 at a clock edge: state <= IDLE, i_hold and d_hold valid and data <= 0.
REQ-038 During reset and the cycle after: m_req_valid=0, i_resp_valid=0, d_resp_valid=0.
REQ-039 rst mid-transaction abandons the outstanding request; a late m_resp_valid arrives in IDLE and is ignored (REQ-035).

Verification
REQ-040 Fetch only: i_req_valid=1, addr 0x2000, ready=1, resp 0x00000013 after 1 cycle -> m_req addr 0x2000 fcn 0 typ MT_WU; i_resp_valid=1 with data 0x13 two cycles after issue; held until retire.
REQ-041 Load: after fetch held, d_req addr 0x100 fcn 0 typ MT_W, resp 0xDEADBEEF -> one data transaction; d_resp_valid=1 with 0xDEADBEEF; retire clears both holds; the next fetch issues.
REQ-042 Store: d_req fcn 1, data 0x55AA55AA, addr 0x104 -> m_req_fcn=1, m_req_data=0x55AA55AA; d_resp_valid=1 after the write-response pulse.
REQ-043 Backpressure: m_req_ready=0 for 3 cycles -> m_req_valid and all fields stable, state stays IDLE; accepted on cycle 4.
REQ-044 Reset in D_WAIT, then m_resp_valid next cycle -> outputs 0, state IDLE, response dropped; a fresh fetch issues afterwards.
REQ-045 d_req_valid=1 while i_hold.valid=0 -> fetch issued first, no data request until the instruction is held.
